// File: rtl/lzc_share_arb.sv
// Round-robin arbiter sharing one pipelined leading-zero counter among N requesters.
// Latency: transfer at edge E -> rsp_valid after edge E+LZC_LATENCY+1; grant is combinational, no response back-pressure.
// Optional perf counters (issue_cnt, idle_cnt, perf_clr) under LZC_SHARE_ARB_PERF_EN.
module lzc_share_arb #(
    parameter int N           = 4,
    parameter int SIZE        = 64,
    parameter int OUT_SIZE    = $clog2(SIZE + 1),
    parameter int LZC_LATENCY = 3,
    parameter int ID_W        = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_en,
    input  logic [N-1:0]        req_valid,
    output logic [N-1:0]        req_ready,
    input  logic [N*SIZE-1:0]   req_data,
    output logic [SIZE-1:0]     lzc_din,
    input  logic [OUT_SIZE-1:0] lzc_dout,
    output logic                rsp_valid,
    output logic [ID_W-1:0]     rsp_id,
    output logic [OUT_SIZE-1:0] rsp_count,
    output logic                busy
`ifdef LZC_SHARE_ARB_PERF_EN
    ,
    input  logic                perf_clr,
    output logic [31:0]         issue_cnt,
    output logic [31:0]         idle_cnt
`endif
);

    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SIZE-1:0]     lzc_din_q, lzc_din_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [OUT_SIZE-1:0] rsp_count_q, rsp_count_d;

    // Stage 0 rides alongside lzc_din; stage LZC_LATENCY lines up with lzc_dout.
    logic [LZC_LATENCY:0]            tag_vld_q, tag_vld_d;
    logic [LZC_LATENCY:0][ID_W-1:0]  tag_id_q, tag_id_d;

    logic [SIZE-1:0] req_op [N];
    logic            gnt_found;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W:0]   scan_sum;
    logic            xfer;

    for (genvar g = 0; g < N; g++) begin : g_op
        assign req_op[g] = req_data[g*SIZE +: SIZE];
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan_sum  = '0;
        req_ready = '0;
        for (int k = 0; k < N; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(N)) begin
                scan_sum = scan_sum - (ID_W+1)'(N);
            end
            if (!gnt_found && req_valid[scan_sum[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = scan_sum[ID_W-1:0];
            end
        end
        if (issue_en && gnt_found) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign xfer = issue_en & gnt_found;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        lzc_din_d   = lzc_din_q;
        if (xfer) begin
            rr_ptr_d  = ({1'b0, gnt_id} == (ID_W+1)'(N - 1)) ? '0 : gnt_id + 1'b1;
            lzc_din_d = req_op[gnt_id];
        end
        tag_vld_d   = {tag_vld_q[LZC_LATENCY-1:0], xfer};
        tag_id_d    = {tag_id_q[LZC_LATENCY-1:0], (xfer ? gnt_id : {ID_W{1'b0}})};
        rsp_valid_d = tag_vld_q[LZC_LATENCY];
        rsp_id_d    = tag_id_q[LZC_LATENCY];
        rsp_count_d = tag_vld_q[LZC_LATENCY] ? lzc_dout : rsp_count_q;
    end

    // Clearing the tags on reset is what discards ops still inside the unreset LZC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            lzc_din_q   <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_count_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lzc_din_q   <= lzc_din_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_count_q <= rsp_count_d;
        end
    end

    assign lzc_din   = lzc_din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_count = rsp_count_q;
    assign busy      = (|tag_vld_q) | rsp_valid_q;

`ifdef LZC_SHARE_ARB_PERF_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] idle_cnt_q, idle_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        if (perf_clr) begin
            issue_cnt_d = '0;
            idle_cnt_d  = '0;
        end else begin
            if (xfer && !(&issue_cnt_q)) begin
                issue_cnt_d = issue_cnt_q + 32'd1;
            end
            if ((|req_valid) && !issue_en && !(&idle_cnt_q)) begin
                idle_cnt_d = idle_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            idle_cnt_q  <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign idle_cnt  = idle_cnt_q;
`endif

endmodule

// File: tb/tb_lzc_share_arb.sv
// Bench for lzc_share_arb: behavioural LZC and reference model, directed cases plus random traffic.
module tb_lzc_share_arb;

    localparam int N        = 4;
    localparam int SIZE     = 64;
    localparam int OUT_SIZE = 7;
    localparam int LAT      = 3;
    localparam int ID_W     = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                issue_en = 1'b0;
    logic [N-1:0]        req_valid = '0;
    logic [N-1:0]        req_ready;
    logic [N*SIZE-1:0]   req_data = '0;
    logic [SIZE-1:0]     lzc_din;
    logic [OUT_SIZE-1:0] lzc_dout;
    logic                rsp_valid;
    logic [ID_W-1:0]     rsp_id;
    logic [OUT_SIZE-1:0] rsp_count;
    logic                busy;
`ifdef LZC_SHARE_ARB_PERF_EN
    logic                perf_clr = 1'b0;
    logic [31:0]         issue_cnt, idle_cnt;
    longint              issue_m, idle_m;
`endif

    lzc_share_arb #(.N(N), .SIZE(SIZE), .OUT_SIZE(OUT_SIZE), .LZC_LATENCY(LAT), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .issue_en(issue_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .lzc_din(lzc_din), .lzc_dout(lzc_dout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_count(rsp_count), .busy(busy)
`ifdef LZC_SHARE_ARB_PERF_EN
        , .perf_clr(perf_clr), .issue_cnt(issue_cnt), .idle_cnt(idle_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clz(input logic [SIZE-1:0] v);
        for (int b = SIZE - 1; b >= 0; b--) begin
            if (v[b]) return SIZE - 1 - b;
        end
        return SIZE;
    endfunction

    // Behavioural shared LZC: LAT register stages, first one samples lzc_din.
    logic [OUT_SIZE-1:0] lzc_pipe [LAT];
    always @(posedge clk) begin
        lzc_pipe[0] <= OUT_SIZE'(clz(lzc_din));
        for (int k = 1; k < LAT; k++) lzc_pipe[k] <= lzc_pipe[k-1];
    end
    assign lzc_dout = lzc_pipe[LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; int id; int cnt; } exp_t;
    exp_t          exp_q[$];
    int            rr_m = 0;
    logic [SIZE-1:0] din_m = '0;
    int            log_id[$];
    int            log_cnt[$];
    int            log_cyc[$];

    // Reference model and per-cycle compare, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            rr_m  = 0;
            din_m = '0;
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_count", rsp_count, 0);
            chk("rst_busy", busy, 0);
            chk("rst_lzc_din", lzc_din, 0);
`ifdef LZC_SHARE_ARB_PERF_EN
            issue_m = 0;
            idle_m  = 0;
            chk("rst_issue_cnt", issue_cnt, 0);
            chk("rst_idle_cnt", idle_cnt, 0);
`endif
        end else begin
            logic exp_v;
            logic [N-1:0] exp_rdy;
            int g;
            exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("rsp_valid", rsp_valid, exp_v);
            if (exp_v) begin
                chk("rsp_id", rsp_id, exp_q[0].id);
                chk("rsp_count", rsp_count, exp_q[0].cnt);
                void'(exp_q.pop_front());
            end
            if (rsp_valid) begin
                log_id.push_back(int'(rsp_id));
                log_cnt.push_back(int'(rsp_count));
                log_cyc.push_back(cyc);
            end
            chk("busy", busy, exp_v || (exp_q.size() > 0));
            chk("lzc_din", lzc_din, din_m);
`ifdef LZC_SHARE_ARB_PERF_EN
            chk("issue_cnt", issue_cnt, issue_m[31:0]);
            chk("idle_cnt", idle_cnt, idle_m[31:0]);
`endif
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(rr_m + k) % N]) g = (rr_m + k) % N;
            end
            exp_rdy = '0;
            if (issue_en && g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
`ifdef LZC_SHARE_ARB_PERF_EN
            if (perf_clr) begin
                issue_m = 0;
                idle_m  = 0;
            end else begin
                if (issue_en && g >= 0 && issue_m < 64'hFFFF_FFFF) issue_m++;
                if (!issue_en && req_valid != 0 && idle_m < 64'hFFFF_FFFF) idle_m++;
            end
`endif
            if (issue_en && g >= 0) begin
                exp_t e;
                e.due = cyc + 1 + LAT + 1;
                e.id  = g;
                e.cnt = clz(req_data[g*SIZE +: SIZE]);
                exp_q.push_back(e);
                din_m = req_data[g*SIZE +: SIZE];
                rr_m  = (g + 1) % N;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_id.delete();
        log_cnt.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [SIZE-1:0] rnd_op();
        logic [SIZE-1:0] v;
        v = {$urandom, $urandom};
        return v >> $urandom_range(0, SIZE);
    endfunction

    initial begin
        int e0;
        int n;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n    = 1'b1;
        issue_en = 1'b1;

        // Single op from requester 2.
        clear_log();
        req_data[2*SIZE +: SIZE] = 64'h0000_0001_0000_0000;
        req_valid = 4'b0100;
        #1;
        chk("single_ready", req_ready, 4'b0100);
        tick();
        e0 = cyc;
        req_valid = '0;
        repeat (7) tick();
        chk("single_nrsp", log_id.size(), 1);
        chk("single_id", log_id[0], 2);
        chk("single_cnt", log_cnt[0], 31);
        chk("single_lat", log_cyc[0] - e0, 4);

        // All-zero then all-ones from requester 0.
        clear_log();
        req_data[0 +: SIZE] = '0;
        req_valid = 4'b0001;
        tick();
        req_data[0 +: SIZE] = '1;
        tick();
        req_valid = '0;
        repeat (7) tick();
        chk("zo_nrsp", log_id.size(), 2);
        chk("zero_cnt", log_cnt[0], 64);
        chk("ones_cnt", log_cnt[1], 0);

        // Full contention from a fresh pointer.
        do_reset();
        clear_log();
        for (int i = 0; i < N; i++) req_data[i*SIZE +: SIZE] = rnd_op();
        req_valid = 4'b1111;
        repeat (8) tick();
        req_valid = '0;
        repeat (8) tick();
        chk("rr_nrsp", log_id.size(), 8);
        for (int k = 0; k < 8; k++) chk("rr_id", log_id[k], k % 4);
        for (int k = 1; k < 8; k++) chk("rr_b2b", log_cyc[k] - log_cyc[k-1], 1);

        // Last grant was 3; 0 and 3 competing.
        req_valid = 4'b1001;
        #1;
        chk("wrap_first", req_ready, 4'b0001);
        tick();
        chk("wrap_second", req_ready, 4'b1000);
        tick();
        req_valid = 4'b0010;
        tick();

        // Freeze the pointer at 2 with issue disabled.
        clear_log();
        issue_en  = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("dis_ready", req_ready, 4'b0000);
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("dis_drained", busy, 0);
        repeat (3) tick();
        n = log_id.size();
        repeat (4) tick();
        chk("dis_no_new_rsp", log_id.size(), n);
        issue_en = 1'b1;
        #1;
        chk("reen_ready", req_ready, 4'b0100);
        req_valid = '0;
        repeat (8) tick();

        // Reset with three ops in flight.
        req_valid = 4'b1111;
        repeat (3) tick();
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
`ifdef LZC_SHARE_ARB_PERF_EN
        chk("midrst_issue_cnt", issue_cnt, 0);
`endif
        tick();
        rst_n = 1'b1;
        clear_log();
        repeat (8) tick();
        chk("midrst_no_rsp", log_id.size(), 0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) req_data[i*SIZE +: SIZE] = rnd_op();
            req_valid = N'($urandom);
            issue_en  = ($urandom_range(0, 9) != 0);
`ifdef LZC_SHARE_ARB_PERF_EN
            perf_clr  = ($urandom_range(0, 199) == 0);
`endif
            if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end
        req_valid = '0;
`ifdef LZC_SHARE_ARB_PERF_EN
        perf_clr  = 1'b0;
`endif
        repeat (10) tick();
        chk("final_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lzc_share_arb.md
Name: lzc_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one externally instantiated pipelined leading-zero counter among N requesters.
- Accepts one operand per cycle from the granted requester and registers it onto the LZC input.
- Tracks each in-flight operation with a tag pipeline matched to the LZC latency, then returns the count to the originating requester.
- Sits between normalisation clients (FP adders, fixed-to-float converters) and the shared LZC.

Parameters:
- N, 4, number of requesters (1..16).
- SIZE, 64, operand width in bits.
- OUT_SIZE, $clog2(SIZE+1), count width.
- LZC_LATENCY, 3, clock edges from the LZC sampling lzc_din to the matching lzc_dout being valid (>=1).
- ID_W, (N>1 ? $clog2(N) : 1), requester-index width.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_en  in  1  when low, no new grants; in-flight ops still complete.
- req_valid  in  N  per-requester operand valid.
- req_ready  out  N  per-requester grant (combinational).
- req_data  in  N*SIZE  operands; requester i occupies bits [i*SIZE +: SIZE].
- lzc_din  out  SIZE  registered operand to the shared LZC.
- lzc_dout  in  OUT_SIZE  LZC result.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  ID_W  index of the requester owning the response.
- rsp_count  out  OUT_SIZE  leading-zero count (SIZE when the operand is all zero).
- busy  out  1  high while any tag is in flight or rsp_valid is high.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - rr_ptr=0, tag pipeline cleared, lzc_din=0.
  - rsp_valid=0, rsp_id=0, rsp_count=0, busy=0.
- Reset mid-operation: all in-flight ops are discarded and no response is produced for them. Any garbage in the unreset LZC pipeline is ignored because its tags are cleared.
- Grant: while issue_en=1, req_ready has at most one bit set. It selects the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N.
  - req_ready depends only on req_valid, issue_en and rr_ptr; it never depends on req_ready.
  - A transfer is req_valid[i] & req_ready[i] at a rising edge.
- On a transfer from requester i:
  - lzc_din <= req_data[i], tag stage 0 <= {1, i}, rr_ptr <= (i+1) mod N.
- With no transfer, lzc_din holds its value, tag stage 0 <= {0, x}, and rr_ptr holds.
- Tag pipeline:
  - LZC_LATENCY stages shift every cycle with no stall.
  - The final stage is aligned with lzc_dout.
  - At each edge: rsp_valid <= last.valid, rsp_id <= last.id, rsp_count <= lzc_dout (rsp_count holds when last.valid=0).
- Latency: a transfer at edge E gives rsp_valid=1 for exactly the cycle after edge E+LZC_LATENCY+1.
- Throughput: one op per cycle. Responses return in issue order, and back-to-back transfers give back-to-back responses.
- No response back-pressure: requesters must accept rsp_valid whenever it is high.
- issue_en deasserted: req_ready=0 and rr_ptr frozen; the pipeline drains normally. Re-assertion resumes from the frozen rr_ptr.
- N=1: requester 0 is always the grant candidate, and rr_ptr and rsp_id are constant 0.
- busy = OR of all tag valids and rsp_valid.

Optional Feature:
- Macro: LZC_SHARE_ARB_PERF_EN.
- When defined, adds:
  - Output port issue_cnt [31:0]: counts transfers.
  - Output port idle_cnt [31:0]: counts cycles with at least one req_valid high but no transfer because issue_en=0.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
  - Input port perf_clr: synchronously zeroes both counters, taking priority over increment in the same cycle.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Single op, N=4, LZC_LATENCY=3, requester 2 sends 64'h0000_0001_0000_0000 at edge 0:
  - req_ready=4'b0100 in the cycle before edge 0.
  - After edge 4: rsp_valid=1, rsp_id=2, rsp_count=31 for one cycle.
- All-zero and all-ones operands from requester 0:
  - 64'h0 gives rsp_count=64.
  - 64'hFFFF_FFFF_FFFF_FFFF gives rsp_count=0.
- All 4 requesters hold req_valid=1 for 8 cycles:
  - Grants go 0,1,2,3,0,1,2,3.
  - Eight consecutive rsp_valid cycles with rsp_id in the same order.
- Requester 3 just granted, then only requesters 0 and 3 valid: next grant is 0, then 3.
- issue_en=0 with req_valid=4'b1111:
  - req_ready=0 and no new responses; busy falls once in-flight ops drain.
  - On re-enable, the grant starts at the frozen rr_ptr.
- rst_n asserted with 3 ops in flight:
  - Outputs go to reset values immediately and no responses appear afterwards.
  - With LZC_SHARE_ARB_PERF_EN defined, issue_cnt reads 0 after reset.
